// File: rtl/stopwatch_counter.sv
// Time-keeping core of the lab3 stopwatch: MM:SS held as four BCD digits,
// with pause/resume and a per-field adjust mode driven by sampled divider outputs.
module stopwatch_counter #(
    parameter int MIN_MAX = 99,
    parameter int SEC_MAX = 59
) (
    input  logic       master_clock,
    input  logic       rst,
    input  logic       clock1hz,
    input  logic       clock_adjust,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       paused
);

    localparam logic [3:0] MIN_MAX_T = 4'(MIN_MAX / 10);
    localparam logic [3:0] MIN_MAX_O = 4'(MIN_MAX % 10);
    localparam logic [3:0] SEC_MAX_T = 4'(SEC_MAX / 10);
    localparam logic [3:0] SEC_MAX_O = 4'(SEC_MAX % 10);

    // A field is treated as "at max" for anything at or beyond its limit, so a
    // corrupted value still wraps back to a legal 00.
    function automatic logic bcd_at_max(input logic [7:0] v,
                                        input logic [3:0] max_t,
                                        input logic [3:0] max_o);
        return (v[7:4] > max_t) || ((v[7:4] == max_t) && (v[3:0] >= max_o));
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [3:0] max_t,
                                           input logic [3:0] max_o);
        logic [3:0] tens_next;
        logic [3:0] ones_next;
        tens_next = v[7:4];
        ones_next = v[3:0] + 4'd1;
        if (bcd_at_max(v, max_t, max_o)) begin
            tens_next = 4'd0;
            ones_next = 4'd0;
        end else if (v[3:0] >= 4'd9) begin
            tens_next = v[7:4] + 4'd1;
            ones_next = 4'd0;
        end
        return {tens_next, ones_next};
    endfunction

    logic       hz_s1_q, hz_s1_d, hz_s2_q, hz_s2_d;
    logic       ca_s1_q, ca_s1_d, ca_s2_q, ca_s2_d;
    logic       pz_s1_q, pz_s1_d, pz_s2_q, pz_s2_d;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic       paused_q, paused_d;
    logic       hz_tick, adj_tick, pause_tick;

    always_comb begin
        hz_s1_d    = clock1hz;
        hz_s2_d    = hz_s1_q;
        ca_s1_d    = clock_adjust;
        ca_s2_d    = ca_s1_q;
        pz_s1_d    = pause;
        pz_s2_d    = pz_s1_q;

        hz_tick    = hz_s1_q & ~hz_s2_q;
        adj_tick   = ca_s1_q & ~ca_s2_q;
        pause_tick = pz_s1_q & ~pz_s2_q;

        min_d      = min_q;
        sec_d      = sec_q;
        paused_d   = paused_q ^ pause_tick;

        // The 1 Hz tick sees the old paused value; a same-cycle toggle lands next cycle.
        if (!adj) begin
            if (hz_tick && !paused_q) begin
                sec_d = bcd_inc(sec_q, SEC_MAX_T, SEC_MAX_O);
                if (bcd_at_max(sec_q, SEC_MAX_T, SEC_MAX_O)) begin
                    min_d = bcd_inc(min_q, MIN_MAX_T, MIN_MAX_O);
                end
            end
        end else if (adj_tick) begin
            if (sel) begin
                sec_d = bcd_inc(sec_q, SEC_MAX_T, SEC_MAX_O);
            end else begin
                min_d = bcd_inc(min_q, MIN_MAX_T, MIN_MAX_O);
            end
        end
    end

    always_ff @(posedge master_clock) begin
        if (rst) begin
            hz_s1_q  <= 1'b0;
            hz_s2_q  <= 1'b0;
            ca_s1_q  <= 1'b0;
            ca_s2_q  <= 1'b0;
            pz_s1_q  <= 1'b0;
            pz_s2_q  <= 1'b0;
            min_q    <= 8'h00;
            sec_q    <= 8'h00;
            paused_q <= 1'b0;
        end else begin
            hz_s1_q  <= hz_s1_d;
            hz_s2_q  <= hz_s2_d;
            ca_s1_q  <= ca_s1_d;
            ca_s2_q  <= ca_s2_d;
            pz_s1_q  <= pz_s1_d;
            pz_s2_q  <= pz_s2_d;
            min_q    <= min_d;
            sec_q    <= sec_d;
            paused_q <= paused_d;
        end
    end

    assign min_tens = min_q[7:4];
    assign min_ones = min_q[3:0];
    assign sec_tens = sec_q[7:4];
    assign sec_ones = sec_q[3:0];
    assign paused   = paused_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: counting, rollover, pause, adjust and
// mid-operation reset, with expected MM:SS values worked out by hand.
module tb_stopwatch_counter;

    logic       master_clock;
    logic       rst;
    logic       clock1hz;
    logic       clock_adjust;
    logic       pause;
    logic       adj;
    logic       sel;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       paused;

    int compared;
    int mismatched;

    stopwatch_counter dut (
        .master_clock (master_clock),
        .rst          (rst),
        .clock1hz     (clock1hz),
        .clock_adjust (clock_adjust),
        .pause        (pause),
        .adj          (adj),
        .sel          (sel),
        .min_tens     (min_tens),
        .min_ones     (min_ones),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .paused       (paused)
    );

    initial master_clock = 1'b0;
    always #5 master_clock = ~master_clock;

    // One-cycle high pulse on the chosen divider/button inputs, then one low cycle;
    // on return the resulting digit update is visible.
    task automatic applyStimulus(input logic hz, input logic ca, input logic pz);
        clock1hz     = hz;
        clock_adjust = ca;
        pause        = pz;
        @(negedge master_clock);
        clock1hz     = 1'b0;
        clock_adjust = 1'b0;
        pause        = 1'b0;
        @(negedge master_clock);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] exp_digits,
                               input logic exp_paused);
        logic [16:0] observed;
        logic [16:0] expected;
        observed = {min_tens, min_ones, sec_tens, sec_ones, paused};
        expected = {exp_digits, exp_paused};
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed digits=%h paused=%b, expected digits=%h paused=%b",
                   tag, observed[16:1], observed[0], expected[16:1], expected[0]);
        end
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        rst          = 1'b1;
        clock1hz     = 1'b0;
        clock_adjust = 1'b0;
        pause        = 1'b0;
        adj          = 1'b0;
        sel          = 1'b0;
        repeat (3) @(negedge master_clock);
        checkOutput("reset_state", 16'h0000, 1'b0);
        rst = 1'b0;
        @(negedge master_clock);

        // First edge: no change one cycle after sampling, update on the next edge.
        clock1hz = 1'b1;
        @(negedge master_clock);
        checkOutput("first_edge_latency", 16'h0000, 1'b0);
        clock1hz = 1'b0;
        @(negedge master_clock);
        checkOutput("first_edge_update", 16'h0001, 1'b0);
        repeat (59) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("sixty_seconds", 16'h0100, 1'b0);

        repeat (5939) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("count_99_59", 16'h9959, 1'b0);
        clock1hz = 1'b1;
        @(negedge master_clock);
        checkOutput("wrap_pending", 16'h9959, 1'b0);
        clock1hz = 1'b0;
        @(negedge master_clock);
        checkOutput("wrap_00_00", 16'h0000, 1'b0);

        rst = 1'b1;
        @(negedge master_clock);
        rst = 1'b0;
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("count_00_05", 16'h0005, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("pause_on", 16'h0005, 1'b1);
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("paused_hold", 16'h0005, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("pause_off", 16'h0005, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("resume_00_06", 16'h0006, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("pause_and_hz_same_cycle", 16'h0007, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("unpause_again", 16'h0007, 1'b0);

        adj = 1'b1;
        sel = 1'b1;
        repeat (51) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("adjust_to_00_58", 16'h0058, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("adj_ignores_hz", 16'h0058, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("adj_sec_59", 16'h0059, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("adj_sec_wrap_no_carry", 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("adj_sec_01", 16'h0001, 1'b0);

        repeat (29) applyStimulus(1'b0, 1'b1, 1'b0);
        sel = 1'b0;
        repeat (98) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("adjust_to_98_30", 16'h9830, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("adj_min_99", 16'h9930, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("adj_min_wrap", 16'h0030, 1'b0);
        adj = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("normal_after_adj", 16'h0031, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("normal_ignores_adjust", 16'h0031, 1'b0);

        // Adjust ticks still step the field while paused.
        applyStimulus(1'b0, 1'b0, 1'b1);
        adj = 1'b1;
        sel = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("adjust_while_paused", 16'h0032, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);

        rst = 1'b1;
        @(negedge master_clock);
        rst = 1'b0;
        sel = 1'b0;
        repeat (12) applyStimulus(1'b0, 1'b1, 1'b0);
        sel = 1'b1;
        repeat (34) applyStimulus(1'b0, 1'b1, 1'b0);
        adj = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("preset_12_34_paused", 16'h1234, 1'b1);
        clock1hz = 1'b1;
        @(negedge master_clock);
        rst = 1'b1;
        @(negedge master_clock);
        rst = 1'b0;
        checkOutput("mid_reset_clears", 16'h0000, 1'b0);
        @(negedge master_clock);
        checkOutput("post_reset_tick_pending", 16'h0000, 1'b0);
        @(negedge master_clock);
        checkOutput("post_reset_one_tick", 16'h0001, 1'b0);
        repeat (4) @(negedge master_clock);
        checkOutput("held_high_single_tick", 16'h0001, 1'b0);
        clock1hz = 1'b0;
        @(negedge master_clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Time-keeping core of the lab3 stopwatch.
- Sits directly downstream of the clock divider. It consumes the divider's clock1hz and clock_adjust outputs as sampled level signals in the master_clock domain.
- Maintains an MM:SS count as four BCD digits, which feed the seven-segment display driver.
- Supports pause/resume and an adjust mode. In adjust mode, the selected field (minutes or seconds) steps at the adjust rate.

Parameters:
- MIN_MAX, 99, highest minutes value before wrap to 00.
- SEC_MAX, 59, highest seconds value before wrap to 00.

Ports:
- master_clock  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- clock1hz  input  1  divider 1 Hz square wave, sampled as data.
- clock_adjust  input  1  divider adjust-rate square wave, sampled as data.
- pause  input  1  debounced, synchronous level from the pause button.
- adj  input  1  1 = adjust mode.
- sel  input  1  adjust field select: 0 = minutes, 1 = seconds.
- min_tens  output  4  BCD minutes tens digit.
- min_ones  output  4  BCD minutes ones digit.
- sec_tens  output  4  BCD seconds tens digit (0-5).
- sec_ones  output  4  BCD seconds ones digit.
- paused  output  1  1 = normal counting frozen.

Behaviour:
- Clocking and reset: one clock domain (master_clock). rst is synchronous and active-high; it is sampled on the rising edge of master_clock and overrides all other inputs.
- Reset values:
  - All four digits = 0.
  - paused = 0.
  - All edge-detect history registers = 0.
- Edge detection:
  - Each of clock1hz, clock_adjust and pause passes through a two-flop chain (s1 <= in; s2 <= s1).
  - Tick = s1 & ~s2, a single-cycle pulse per rising edge of the input.
  - An input first seen high at edge N (low at N-1) produces a tick during cycle N to N+1. Its effect appears in registers at edge N+1.
  - Because history is reset to 0, an input already high during the first post-reset cycle produces one tick.
- Counter state: held as BCD digits directly (no binary-to-BCD conversion).
  - Increment of a field: ones+1; if ones==9 then ones=0 and tens+1.
  - Field at its max (MIN_MAX or SEC_MAX) wraps to 00.
- Pause: a pause tick toggles paused.
  - The pause tick and a 1 Hz tick in the same cycle: the 1 Hz tick is evaluated against the old paused value; the toggle takes effect from the next cycle.
  - Pause works in both modes.
- Normal mode (adj=0):
  - On a 1 Hz tick with paused=0, seconds increment.
  - Seconds 59 -> 00 carries +1 into minutes.
  - 99:59 -> 00:00.
  - clock_adjust ticks are ignored.
- Adjust mode (adj=1):
  - 1 Hz ticks are ignored, regardless of paused.
  - Each adjust tick increments only the field chosen by sel.
  - No carry between fields: seconds 59 -> 00 leaves minutes unchanged; minutes 99 -> 00.
  - Adjust ticks apply regardless of paused.
- Mode or sel changes take effect on the same cycle they are sampled. No count is lost or duplicated across a mode change, other than a tick arriving in that exact cycle, which uses the new adj/sel values.
- Digit outputs are registered; no combinational path from inputs to outputs.
- Digits never leave legal BCD: sec_tens is 0-5 and every ones digit is 0-9 in all cases.

Test Plan:
- Reset then 60 rising edges of clock1hz with adj=0 and pause low -> digits read 01:00. Each change lands exactly one master_clock cycle after the sampled rising edge.
- Counting to 99:59, then one more 1 Hz edge -> 00:00; min_tens and sec_tens roll over in the same cycle.
- Pause tested in three steps:
  - Count to 00:05, then one pause rising edge -> paused=1.
  - Ten further 1 Hz edges -> digits stay 00:05.
  - Second pause edge -> paused=0; the next 1 Hz edge gives 00:06.
- adj=1, sel=1, digits at 00:58; three clock_adjust edges -> 00:59, 00:00, 00:01 with minutes unchanged. 1 Hz edges during the test have no effect.
- adj=1, sel=0, digits at 98:30; two clock_adjust edges -> 99:30, then 00:30. Switch to adj=0 -> the next 1 Hz edge gives 00:31.
- Mid-operation reset:
  - Assert rst for one cycle at 12:34 while paused=1 and clock1hz is high -> next cycle shows 00:00 with paused=0.
  - clock1hz still high in the first post-reset cycle -> exactly one tick, giving 00:01.
